control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Main decoder plus ALU-control decoder for a single-cycle RV32I-subset core.
- Consumes the opcode, funct3 and funct7 fields of the fetched instruction and the ALU zero flag.
- Produces datapath control: branch-taken, memory read/write, write-back select, ALU source select, register write and a 4-bit ALU operation code.
- All decode is combinational. A sticky illegal-instruction flag is the only state.

Parameters:
- none

Ports:
- clk  input  1  clock; used only by the sticky error flag
- reset  input  1  synchronous, active-high reset
- f7  input  7  instruction funct7 field [31:25]
- f3  input  3  instruction funct3 field [14:12]
- op  input  7  instruction opcode [6:0]
- z  input  1  ALU zero flag of the current instruction
- b  output  1  branch taken (PC-select)
- mR  output  1  data-memory read enable
- m2r  output  1  write-back select: 1 = memory data, 0 = ALU result
- aluOp  output  4  ALU operation code
- mW  output  1  data-memory write enable
- aluSrc  output  1  ALU operand B: 1 = immediate, 0 = rs2
- rW  output  1  register-file write enable
- illegal  output  1  combinational: current instruction not supported
- illegal_seen  output  1  sticky registered error flag

Behaviour:
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1101.
- Combinational outputs are pure functions of op/f3/f7/z with zero latency. They ignore clk and reset.
- R-type (op 0110011): rW=1; aluSrc=0; mR=mW=m2r=b=0. ALU code by {f7,f3}:
  - 0000000_000 ADD; 0100000_000 SUB; 0000000_111 AND; 0000000_110 OR
  - 0000000_100 XOR; 0000000_001 SLL; 0000000_101 SRL; 0100000_101 SRA; 0000000_010 SLT
  - any other {f7,f3} is illegal.
- I-ALU (op 0010011): rW=1; aluSrc=1; others 0. ALU code by f3:
  - 000 ADD; 111 AND; 110 OR; 100 XOR; 010 SLT
  - 001 SLL requires f7=0000000
  - 101 SRL requires f7=0000000; SRA requires f7=0100000
  - anything else is illegal.
- Load (op 0000011): mR=1; m2r=1; aluSrc=1; rW=1; mW=0; b=0; aluOp=ADD. f3 ignored.
- Store (op 0100011): mW=1; aluSrc=1; rW=0; mR=0; m2r=0; b=0; aluOp=ADD. f3 ignored.
- Branch (op 1100011): aluOp=SUB; aluSrc=0; rW=mR=mW=m2r=0.
  - f3=000 (beq): b=z.
  - f3=001 (bne): b=~z.
  - other f3 is illegal.
- b is gated by the branch decode. b=0 for every non-branch opcode even when z is X/unknown; no X may propagate to b.
- Illegal instruction (unknown opcode or rejected field combination):
  - illegal=1
  - b=mR=mW=rW=m2r=aluSrc=0; aluOp=ADD
- illegal=0 for all legal encodings.
- illegal_seen timing:
  - On rising clk with reset=1, clears to 0 (reset has priority).
  - Otherwise it becomes illegal_seen | illegal.
  - It stays set until the next reset.
- illegal_seen is X-safe: an X on illegal before reset does not matter, since reset defines the state.
- Reset mid-operation affects only illegal_seen. Decode outputs keep tracking their inputs.

Test Plan:
- op=0110011, {f7,f3} = 0000000_000 / 0100000_000 / 0000000_111 / 0000000_110 -> aluOp = 0010 / 0110 / 0000 / 0001; rW=1; aluSrc=mR=mW=m2r=b=0; z left X.
- op=0000011 -> mR=1, m2r=1, aluSrc=1, rW=1, mW=0, b=0, aluOp=0010. Then op=0100011 -> mW=1, aluSrc=1, rW=0, mR=0, b=0, aluOp=0010.
- op=1100011, f3=000:
  - z=1 -> b=1, aluOp=0110, aluSrc=0, rW=mR=mW=0.
  - z=0 -> b=0.
  - f3=001 with z=0/1 -> b=1/0.
- op=0010011: f3=000 -> aluOp=0010, aluSrc=1, rW=1. f3=101 with f7=0100000 -> aluOp=1101.
- Sticky flag sequence:
  - reset=1 for one clk edge -> illegal_seen=0.
  - op=1111111 -> illegal=1, all enables 0; next edge -> illegal_seen=1.
  - op=0110011 legal -> illegal=0, illegal_seen remains 1.
  - reset edge -> illegal_seen=0.
- Invalid R-type funct7=0100000 with f3=111 -> illegal=1, rW=0, aluOp=0010.

Source files
------------

// File: rtl/control_unit.sv
// Main decoder plus ALU-control decoder for a single-cycle RV32I-subset core.
// Decode is purely combinational; the sticky illegal-instruction flag is the only state.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] f7,
  input  logic [2:0] f3,
  input  logic [6:0] op,
  input  logic       z,
  output logic       b,
  output logic       mR,
  output logic       m2r,
  output logic [3:0] aluOp,
  output logic       mW,
  output logic       aluSrc,
  output logic       rW,
  output logic       illegal,
  output logic       illegal_seen
);
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_XOR = 4'b0011, ALU_SLL = 4'b0100, ALU_SRL = 4'b0101,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SRA = 4'b1101;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I  = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;
  localparam logic [6:0] F7_0 = 7'b0000000, F7_ALT = 7'b0100000;

  logic       w_b, w_mR, w_m2r, w_mW, w_aluSrc, w_rW, w_ill;
  logic [3:0] w_aluOp;
  logic       r_illegal_seen;

  always_comb begin
    w_b      = 1'b0;
    w_mR     = 1'b0;
    w_m2r    = 1'b0;
    w_mW     = 1'b0;
    w_aluSrc = 1'b0;
    w_rW     = 1'b0;
    w_ill    = 1'b0;
    w_aluOp  = ALU_ADD;
    case (op)
      OP_R: begin
        w_rW = 1'b1;
        case ({f7, f3})
          {F7_0,   3'b000}: w_aluOp = ALU_ADD;
          {F7_ALT, 3'b000}: w_aluOp = ALU_SUB;
          {F7_0,   3'b111}: w_aluOp = ALU_AND;
          {F7_0,   3'b110}: w_aluOp = ALU_OR;
          {F7_0,   3'b100}: w_aluOp = ALU_XOR;
          {F7_0,   3'b001}: w_aluOp = ALU_SLL;
          {F7_0,   3'b101}: w_aluOp = ALU_SRL;
          {F7_ALT, 3'b101}: w_aluOp = ALU_SRA;
          {F7_0,   3'b010}: w_aluOp = ALU_SLT;
          default:          w_ill   = 1'b1;
        endcase
      end
      OP_I: begin
        w_rW     = 1'b1;
        w_aluSrc = 1'b1;
        case (f3)
          3'b000: w_aluOp = ALU_ADD;
          3'b111: w_aluOp = ALU_AND;
          3'b110: w_aluOp = ALU_OR;
          3'b100: w_aluOp = ALU_XOR;
          3'b010: w_aluOp = ALU_SLT;
          3'b001: if (f7 == F7_0) w_aluOp = ALU_SLL; else w_ill = 1'b1;
          3'b101: begin
            if (f7 == F7_0)        w_aluOp = ALU_SRL;
            else if (f7 == F7_ALT) w_aluOp = ALU_SRA;
            else                   w_ill   = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OP_LD: begin
        w_mR     = 1'b1;
        w_m2r    = 1'b1;
        w_aluSrc = 1'b1;
        w_rW     = 1'b1;
      end
      OP_ST: begin
        w_mW     = 1'b1;
        w_aluSrc = 1'b1;
      end
      OP_BR: begin
        w_aluOp = ALU_SUB;
        // z is only consulted here, so an unknown z never reaches b elsewhere
        case (f3)
          3'b000:  w_b   = z;
          3'b001:  w_b   = ~z;
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_b      = 1'b0;
      w_mR     = 1'b0;
      w_m2r    = 1'b0;
      w_mW     = 1'b0;
      w_aluSrc = 1'b0;
      w_rW     = 1'b0;
      w_aluOp  = ALU_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_illegal_seen <= 1'b0;
    else       r_illegal_seen <= r_illegal_seen | w_ill;
  end

  assign b            = w_b;
  assign mR           = w_mR;
  assign m2r          = w_m2r;
  assign aluOp        = w_aluOp;
  assign mW           = w_mW;
  assign aluSrc       = w_aluSrc;
  assign rW           = w_rW;
  assign illegal      = w_ill;
  assign illegal_seen = r_illegal_seen;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode vectors with hand-computed controls,
// then the sticky illegal flag across reset.
module tb_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] f7, op;
  logic [2:0] f3;
  logic       z;
  logic       b, mR, m2r, mW, aluSrc, rW, illegal, illegal_seen;
  logic [3:0] aluOp;
  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .f7(f7), .f3(f3), .op(op), .z(z),
    .b(b), .mR(mR), .m2r(m2r), .aluOp(aluOp), .mW(mW), .aluSrc(aluSrc),
    .rW(rW), .illegal(illegal), .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  // Control vector packing: {b, mR, m2r, aluOp[3:0], mW, aluSrc, rW, illegal}
  task automatic apply(input logic [6:0] i_op, input logic [6:0] i_f7,
                       input logic [2:0] i_f3, input logic i_z);
    @(negedge clk);
    op = i_op; f7 = i_f7; f3 = i_f3; z = i_z;
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {b, mR, m2r, aluOp, mW, aluSrc, rW, illegal};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_seen(input string tag, input logic exp);
    checks++;
    assert (illegal_seen === exp) else begin
      errors++;
      $error("FAIL %s illegal_seen observed=%b expected=%b", tag, illegal_seen, exp);
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'b0110011; f7 = 7'b0; f3 = 3'b0; z = 1'bx;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_seen("reset_clear", 1'b0);

    // R-type, z left unknown
    apply(7'b0110011, 7'b0000000, 3'b000, 1'bx); chk_ctl("r_add", 11'b0_0_0_0010_0_0_1_0);
    apply(7'b0110011, 7'b0100000, 3'b000, 1'bx); chk_ctl("r_sub", 11'b0_0_0_0110_0_0_1_0);
    apply(7'b0110011, 7'b0000000, 3'b111, 1'bx); chk_ctl("r_and", 11'b0_0_0_0000_0_0_1_0);
    apply(7'b0110011, 7'b0000000, 3'b110, 1'bx); chk_ctl("r_or",  11'b0_0_0_0001_0_0_1_0);
    apply(7'b0110011, 7'b0000000, 3'b100, 1'bx); chk_ctl("r_xor", 11'b0_0_0_0011_0_0_1_0);
    apply(7'b0110011, 7'b0000000, 3'b001, 1'bx); chk_ctl("r_sll", 11'b0_0_0_0100_0_0_1_0);
    apply(7'b0110011, 7'b0000000, 3'b101, 1'bx); chk_ctl("r_srl", 11'b0_0_0_0101_0_0_1_0);
    apply(7'b0110011, 7'b0100000, 3'b101, 1'bx); chk_ctl("r_sra", 11'b0_0_0_1101_0_0_1_0);
    apply(7'b0110011, 7'b0000000, 3'b010, 1'bx); chk_ctl("r_slt", 11'b0_0_0_0111_0_0_1_0);

    // Load / store, f3 ignored, z unknown
    apply(7'b0000011, 7'b0000000, 3'b010, 1'bx); chk_ctl("load",  11'b0_1_1_0010_0_1_1_0);
    apply(7'b0100011, 7'b1111111, 3'b111, 1'bx); chk_ctl("store", 11'b0_0_0_0010_1_1_0_0);

    // Branches
    apply(7'b1100011, 7'b0000000, 3'b000, 1'b1); chk_ctl("beq_z1", 11'b1_0_0_0110_0_0_0_0);
    apply(7'b1100011, 7'b0000000, 3'b000, 1'b0); chk_ctl("beq_z0", 11'b0_0_0_0110_0_0_0_0);
    apply(7'b1100011, 7'b0000000, 3'b001, 1'b0); chk_ctl("bne_z0", 11'b1_0_0_0110_0_0_0_0);
    apply(7'b1100011, 7'b0000000, 3'b001, 1'b1); chk_ctl("bne_z1", 11'b0_0_0_0110_0_0_0_0);

    // I-ALU
    apply(7'b0010011, 7'b0000000, 3'b000, 1'bx); chk_ctl("i_add", 11'b0_0_0_0010_0_1_1_0);
    apply(7'b0010011, 7'b0100000, 3'b101, 1'bx); chk_ctl("i_sra", 11'b0_0_0_1101_0_1_1_0);
    apply(7'b0010011, 7'b0000000, 3'b101, 1'bx); chk_ctl("i_srl", 11'b0_0_0_0101_0_1_1_0);
    apply(7'b0010011, 7'b0000000, 3'b001, 1'bx); chk_ctl("i_sll", 11'b0_0_0_0100_0_1_1_0);
    apply(7'b0010011, 7'b1010101, 3'b110, 1'bx); chk_ctl("i_or",  11'b0_0_0_0001_0_1_1_0);

    @(negedge clk);
    chk_seen("seen_after_legal", 1'b0);

    // Illegal encodings
    apply(7'b1111111, 7'b0000000, 3'b000, 1'b1); chk_ctl("bad_op", 11'b0_0_0_0010_0_0_0_1);
    @(negedge clk);
    #1;
    chk_seen("seen_set", 1'b1);
    apply(7'b0110011, 7'b0000000, 3'b000, 1'bx); chk_ctl("legal_after_bad", 11'b0_0_0_0010_0_0_1_0);
    @(negedge clk);
    #1;
    chk_seen("seen_sticky", 1'b1);
    apply(7'b0110011, 7'b0100000, 3'b111, 1'b1); chk_ctl("r_bad_f7", 11'b0_0_0_0010_0_0_0_1);
    apply(7'b0010011, 7'b0100000, 3'b001, 1'b1); chk_ctl("i_sll_bad_f7", 11'b0_0_0_0010_0_0_0_1);
    apply(7'b0010011, 7'b0000001, 3'b101, 1'b1); chk_ctl("i_sr_bad_f7", 11'b0_0_0_0010_0_0_0_1);
    apply(7'b0010011, 7'b0000000, 3'b011, 1'b1); chk_ctl("i_bad_f3", 11'b0_0_0_0010_0_0_0_1);
    apply(7'b1100011, 7'b0000000, 3'b100, 1'b1); chk_ctl("br_bad_f3", 11'b0_0_0_0010_0_0_0_1);

    // Reset has priority over a concurrent illegal; decode keeps tracking inputs
    reset = 1'b1;
    #1;
    chk_ctl("decode_during_reset", 11'b0_0_0_0010_0_0_0_1);
    @(negedge clk);
    #1;
    chk_seen("reset_priority", 1'b0);
    apply(7'b0000011, 7'b0000000, 3'b000, 1'bx); chk_ctl("load_in_reset", 11'b0_1_1_0010_0_1_1_0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk_seen("seen_after_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
